// File: rtl/addsub_serial.sv
// Digit-serial signed adder/subtractor: DIGIT bits per cycle, least significant digit first,
// with optional saturation on signed overflow. Results appear on s/cout/overflow with a done pulse.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow,
   output logic             o_dbg_state
);

   localparam int K    = WIDTH / DIGIT;
   localparam int IDXW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Handshake: start is taken only at an edge where busy=0; done pulses for one cycle
   // once s/cout/overflow carry the new result, and those outputs then hold until the next done.
   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_s;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_carry;
   logic             r_sat;
   logic             r_cout;
   logic             r_ovf;
   logic             r_done;
   logic [IDXW-1:0]  r_idx;

   logic [DIGIT:0]   w_dsum;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (r_idx == IDXW'(K - 1)) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Operands shift down one digit per cycle; the sum shifts in from the top, so after
   // K cycles the freshly shifted value is the complete raw result.
   always_comb begin
      w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
      w_raw  = WIDTH'({w_dsum[DIGIT-1:0], r_sum} >> DIGIT);
      w_ovf  = (r_a_msb == r_b_msb) && (w_raw[WIDTH-1] != r_a_msb);
      w_res  = w_raw;
      if (r_sat && w_ovf)
         w_res = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_s     <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_carry <= 1'b0;
         r_sat   <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1] ^ sub;
            r_carry <= sub;
            r_sat   <= sat;
            r_sum   <= '0;
            r_idx   <= '0;
         end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_sum   <= w_raw;
            r_idx   <= r_idx + IDXW'(1);
            if (w_last) begin
               r_s    <= w_res;
               r_cout <= w_dsum[DIGIT];
               r_ovf  <= w_ovf;
               r_done <= 1'b1;
               r_idx  <= '0;
            end
         end
      end
   end

   assign busy        = (r_state == RUN);
   assign o_dbg_state = (r_state == RUN);
   assign done        = r_done;
   assign s           = r_s;
   assign cout        = r_cout;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomized checks of addsub_serial against an integer-arithmetic reference model.
module tb_addsub_serial;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int K     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             sat;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             overflow;
   logic             dbg_state;

   int               n_vec = 0;
   int               n_err = 0;
   logic [9:0]       exp_q[$];
   logic [7:0]       last_s;

   addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .sat(sat),
      .busy(busy), .done(done), .s(s), .cout(cout), .overflow(overflow),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain signed integer arithmetic; packs {cout, overflow, s}.
   function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic msub, input logic msat);
      int         sa, sb, full;
      logic [7:0] rs;
      logic       c, o;
      sa   = $signed(ma);
      sb   = $signed(mb);
      full = msub ? (sa - sb) : (sa + sb);
      o    = (full > 127) || (full < -128);
      rs   = full[7:0];
      if (msub) c = (ma >= mb);
      else      c = ((int'(ma) + int'(mb)) > 255);
      if (msat && o) rs = (full > 0) ? 8'h7F : 8'h80;
      return {c, o, rs};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                         input logic osat, input logic noisy);
      logic [9:0] e;
      int         lat;
      bit         got;
      a     = oa;
      b     = ob;
      sub   = osub;
      sat   = osat;
      start = 1'b1;
      exp_q.push_back(model(oa, ob, osub, osat));
      tick;
      check("accept_busy", busy, 1);
      check("accept_no_done", done, 0);
      start = 1'b0;
      got   = 0;
      lat   = 0;
      for (int c = 1; c <= 3 * K && !got; c++) begin
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            a     = 8'($urandom);
            b     = 8'($urandom);
            sub   = 1'($urandom_range(0, 1));
            sat   = 1'($urandom_range(0, 1));
         end
         tick;
         lat = c;
         if (done) got = 1;
         else      check("hold_s", s, last_s);
      end
      start = 1'b0;
      check("done_seen", got, 1);
      check("latency", lat, K);
      check("busy_at_done", busy, 0);
      e = exp_q.pop_front();
      check("s", s, e[7:0]);
      check("overflow", overflow, e[8]);
      check("cout", cout, e[9]);
      last_s = e[7:0];
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      sub    = 1'b0;
      sat    = 1'b0;
      last_s = '0;
      tick;
      tick;
      check_idle("reset");
      check("reset_s", s, 0);
      check("reset_cout", cout, 0);
      check("reset_ovf", overflow, 0);
      check("reset_state", dbg_state, 0);
      rst = 1'b0;
      tick;
      check_idle("post_reset");

      // Directed cases, issued back-to-back (start during each done cycle).
      run_op(8'd100, 8'd27, 1'b0, 1'b0, 1'b0);
      run_op(8'd100, 8'd28, 1'b0, 1'b0, 1'b0);
      run_op(8'd100, 8'd28, 1'b0, 1'b1, 1'b0);
      run_op(8'h80,  8'd1,  1'b1, 1'b0, 1'b0);
      run_op(8'h80,  8'd1,  1'b1, 1'b1, 1'b0);
      run_op(8'd5,   8'd7,  1'b1, 1'b0, 1'b0);
      run_op(8'd7,   8'd5,  1'b1, 1'b0, 1'b0);
      run_op(8'h7F,  8'h7F, 1'b0, 1'b1, 1'b0);
      run_op(8'h80,  8'h80, 1'b0, 1'b1, 1'b0);
      run_op(8'h00,  8'h00, 1'b1, 1'b0, 1'b0);
      run_op(8'h80,  8'h7F, 1'b1, 1'b1, 1'b0);
      // Start pulses and operand churn while busy must not disturb the result.
      run_op(8'd50,  8'd60, 1'b0, 1'b1, 1'b1);
      tick;
      check_idle("after_noisy");

      // Abort in the second RUN cycle.
      a     = 8'd90;
      b     = 8'd10;
      sub   = 1'b0;
      sat   = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      check_idle("abort");
      check("abort_s", s, 0);
      check("abort_cout", cout, 0);
      check("abort_ovf", overflow, 0);
      rst    = 1'b0;
      last_s = '0;
      for (int i = 0; i < 6; i++) begin
         tick;
         check_idle("abort_quiet");
      end
      run_op(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            tick;
            check_idle("gap");
         end
      end

      tick;
      check_idle("final");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits processed per cycle; SHALL divide WIDTH exactly, and K = WIDTH/DIGIT is the number of digit cycles.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request to begin an operation; accepted only when busy=0.
REQ-006 Port a  input  WIDTH  signed two's-complement operand A; sampled on an accepted start.
REQ-007 Port b  input  WIDTH  signed two's-complement operand B; sampled on an accepted start.
REQ-008 Port sub  input  1  0: S = A+B, 1: S = A-B; sampled on an accepted start.
REQ-009 Port sat  input  1  1: saturate on overflow; sampled on an accepted start.
REQ-010 Port busy  output  1  high while an operation is in progress.
REQ-011 Port done  output  1  one-cycle pulse; results valid.
REQ-012 Port s  output  WIDTH  signed result.
REQ-013 Port cout  output  1  carry out of the MSB of A + (B xor {sub}) + sub, unaffected by saturation.
REQ-014 Port overflow  output  1  signed overflow of the unsaturated result.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and RUN; busy=1 iff state=RUN.
REQ-016 In IDLE, start=1 at an edge SHALL latch a, b xor {WIDTH{sub}}, carry=sub, sat, clear digit index to 0, and enter RUN.
REQ-017 In RUN, each edge SHALL add digit[idx] of latched A, digit[idx] of latched B', and carry; it SHALL store the DIGIT-bit sum in the result register, update carry, and increment idx.
REQ-018 At the edge processing idx=K-1, the block SHALL return to IDLE, drive s/cout/overflow, and drive done=1 for exactly the following cycle.
REQ-019 Latency SHALL be: start accepted at edge E0, results and done visible after edge EK, with no other wait states.
REQ-020 overflow SHALL be 1 iff A[MSB]==B'[MSB] and the raw sum MSB differs from A[MSB].
REQ-021 If sat=1 and overflow=1, s SHALL be the max positive value (0111..1) when A[MSB]=0, else the min negative value (1000..0); otherwise s SHALL be the raw wrapped sum.
REQ-022 start while busy=1 SHALL be ignored, and operands, sub and sat changing during RUN SHALL have no effect.
REQ-023 start at the same edge that completes an operation SHALL NOT be accepted; start during the cycle done=1 SHALL be accepted, making back-to-back operations K+1 cycles apart.
REQ-024 s, cout and overflow SHALL hold their value from done until the next completion; they are undefined-free but not updated during RUN.
REQ-025 Intermediate digit results SHALL NOT be visible on s before done.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, s=0, cout=0, overflow=0, idx=0 and carry=0, taking priority over start.
REQ-027 rst asserted during RUN SHALL abort the operation with no done pulse; a start after rst deasserts SHALL behave as a fresh operation.

Verification (WIDTH=8, DIGIT=2, K=4)
REQ-028 a=100, b=27, sub=0, sat=0 -> done 4 cycles after start, s=127, overflow=0, cout=0.
REQ-029 a=100, b=28, sub=0 -> sat=0: s=-128, overflow=1; sat=1: s=127, overflow=1.
REQ-030 a=-128, b=1, sub=1 -> sat=0: s=127, cout=1, overflow=1; sat=1: s=-128, overflow=1.
REQ-031 a=5, b=7, sub=1 -> s=-2, cout=0, overflow=0; a=7, b=5, sub=1 -> s=2, cout=1, overflow=0.
REQ-032 A second start pulsed while busy, with operands toggled mid-RUN -> result is that of the first operands only, and exactly one done pulse.
REQ-033 rst during the 2nd RUN cycle -> busy=0 and all outputs 0 next cycle, no done; a following start of 3+4 -> s=7 with normal latency.
